// File: rtl/bcd_digit_entry.sv
// Keypad digit entry: debounces one key line, shifts valid BCD digits into a
// four-digit register, and scans that register onto a multiplexed 7-segment display.
module bcd_digit_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_pressed,
    input  logic [3:0]  digit_in,
    input  logic        clear,
    output logic [15:0] bcd_value,
    output logic [2:0]  digit_count,
    output logic        accept,
    output logic        err,
    output logic        overflow,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    // The state change out of IDLE or HELD is itself the first sample of a run,
    // so the run counter only has to see DEBOUNCE_CYCLES-1 further samples.
    localparam logic [8:0]  DB_TARGET  = 9'(DEBOUNCE_CYCLES);
    localparam bit          DB_SINGLE  = (DEBOUNCE_CYCLES == 1);
    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  run_cnt;
    logic [7:0]  run_next;
    logic        run_done;
    logic        press_evt;

    logic [15:0] prescale;
    logic [1:0]  idx;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] code;
        case (bcd)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    assign run_done = ({1'b0, run_cnt} + 9'd2) >= DB_TARGET;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every always_ff block sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            run_cnt <= '0;
        end else begin
            state   <= state_next;
            run_cnt <= run_next;
        end
    end

    // NOTE: every variable gets a default at the top of the block so that no
    // path through the case statement leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        run_next   = run_cnt;
        case (state)
            IDLE: begin
                if (key_pressed) state_next = DB_SINGLE ? HELD : PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!key_pressed)  state_next = IDLE;
                else if (run_done) state_next = HELD;
                else               run_next   = run_cnt + 8'd1;
            end
            HELD: begin
                if (!key_pressed) state_next = DB_SINGLE ? IDLE : RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (key_pressed)   state_next = HELD;
                else if (run_done) state_next = IDLE;
                else               run_next   = run_cnt + 8'd1;
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state) run_next = '0;
    end

    // Single-cycle acceptance strobe on the edge that completes a high run.
    always_comb begin
        press_evt = 1'b0;
        case (state)
            IDLE:       press_evt = key_pressed && DB_SINGLE;
            PRESS_WAIT: press_evt = key_pressed && run_done;
            default:    press_evt = 1'b0;
        endcase
    end

    // Clear wins over a simultaneous acceptance: the digit is dropped silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_value   <= '0;
            digit_count <= '0;
            accept      <= 1'b0;
            err         <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            accept   <= 1'b0;
            err      <= 1'b0;
            overflow <= 1'b0;
            if (clear) begin
                bcd_value   <= '0;
                digit_count <= '0;
            end else if (press_evt) begin
                if (digit_in > 4'd9) begin
                    err <= 1'b1;
                end else if (digit_count >= 3'd4) begin
                    overflow <= 1'b1;
                end else begin
                    bcd_value   <= {bcd_value[11:0], digit_in};
                    digit_count <= digit_count + 3'd1;
                    accept      <= 1'b1;
                end
            end
        end
    end

    // Display scan: an/seg are registered from the current idx and contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= '0;
            idx      <= '0;
            an       <= 4'b0001;
            seg      <= 7'h00;
        end else begin
            if (prescale == SCAN_LAST) begin
                prescale <= '0;
                idx      <= idx + 2'd1;
            end else begin
                prescale <= prescale + 16'd1;
            end
            an  <= 4'b0001 << idx;
            seg <= ({1'b0, idx} < digit_count) ? seg_decode(bcd_value[{idx, 2'b00} +: 4])
                                               : 7'h00;
        end
    end

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Self-checking bench for bcd_digit_entry: directed scenarios followed by random
// key/clear/reset traffic, all compared against a run-length behavioural model.
module tb_bcd_digit_entry;

    localparam int DC = 4;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_pressed;
    logic [3:0]  digit_in;
    logic        clear;
    logic [15:0] bcd_value;
    logic [2:0]  digit_count;
    logic        accept;
    logic        err;
    logic        overflow;
    logic [6:0]  seg;
    logic [3:0]  an;

    always #5 clk = ~clk;

    bcd_digit_entry #(
        .DEBOUNCE_CYCLES(DC),
        .SCAN_DIV       (SD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_pressed(key_pressed),
        .digit_in   (digit_in),
        .clear      (clear),
        .bcd_value  (bcd_value),
        .digit_count(digit_count),
        .accept     (accept),
        .err        (err),
        .overflow   (overflow),
        .seg        (seg),
        .an         (an)
    );

    int checks = 0;
    int errors = 0;

    // Model: a press counts when an armed key sees DC consecutive highs; the key
    // re-arms after DC consecutive lows. Entered digits live in a queue, oldest first.
    int  high_run;
    int  low_run;
    bit  armed;
    int  digits[$];
    int  scan_n;
    int  acc_seen;
    int  err_seen;
    int  ov_seen;
    logic [6:0] seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] model_value();
        logic [15:0] v = '0;
        for (int i = 0; i < digits.size(); i++) v = 16'(v * 16 + digits[i]);
        return v;
    endfunction

    task automatic step(input logic k, input logic [3:0] d, input logic c, input logic r);
        int         idx;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        bit         acc;
        bit         er;
        bit         ov;
        key_pressed = k;
        digit_in    = d;
        clear       = c;
        rst         = r;
        idx = (scan_n / SD) % 4;
        if (r || idx >= digits.size()) exp_seg = 7'h00;
        else                           exp_seg = seg_tbl[digits[digits.size() - 1 - idx]];
        exp_an = r ? 4'b0001 : 4'(1 << idx);
        acc = 1'b0;
        er  = 1'b0;
        ov  = 1'b0;
        if (r) begin
            armed    = 1'b1;
            high_run = 0;
            low_run  = 0;
            scan_n   = 0;
            digits.delete();
        end else begin
            scan_n++;
            if (k) begin
                high_run++;
                low_run = 0;
            end else begin
                low_run++;
                high_run = 0;
            end
            if (armed && high_run == DC) begin
                armed = 1'b0;
                if (!c) begin
                    if (d > 4'd9)              er = 1'b1;
                    else if (digits.size() == 4) ov = 1'b1;
                    else begin
                        digits.push_back(int'(d));
                        acc = 1'b1;
                    end
                end
            end else if (!armed && low_run >= DC) begin
                armed = 1'b1;
            end
            if (c) digits.delete();
        end
        @(posedge clk);
        #1;
        check("bcd_value",   32'(bcd_value),   32'(model_value()));
        check("digit_count", 32'(digit_count), 32'(digits.size()));
        check("accept",      32'(accept),      32'(acc));
        check("err",         32'(err),         32'(er));
        check("overflow",    32'(overflow),    32'(ov));
        check("seg",         32'(seg),         32'(exp_seg));
        check("an",          32'(an),          32'(exp_an));
        if (accept)   acc_seen++;
        if (err)      err_seen++;
        if (overflow) ov_seen++;
    endtask

    task automatic press(input logic [3:0] d);
        for (int i = 0; i < DC + 2; i++) step(1'b1, d, 1'b0, 1'b0);
        for (int i = 0; i < DC + 1; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        acc_seen = 0;
        err_seen = 0;
        ov_seen  = 0;
    endtask

    initial begin
        logic k;
        clear_counts();
        armed    = 1'b1;
        high_run = 0;
        low_run  = 0;
        scan_n   = 0;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b0, 1'b1);

        // Bounce rejection: 3 highs, 1 low, then 4 highs with digit 7
        clear_counts();
        for (int i = 0; i < 3; i++) step(1'b1, 4'd7, 1'b0, 1'b0);
        step(1'b0, 4'd7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'd7, 1'b0, 1'b0);
        check("bounce_no_early_accept", 32'(acc_seen), 32'd0);
        step(1'b1, 4'd7, 1'b0, 1'b0);
        check("bounce_accept_4th", 32'(accept), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b1, 4'd7, 1'b0, 1'b0);
        for (int i = 0; i < DC + 1; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
        check("bounce_accepts", 32'(acc_seen), 32'd1);
        check("bounce_value", 32'(bcd_value), 32'h0007);
        check("bounce_count", 32'(digit_count), 32'd1);

        // Entry and overflow
        step(1'b0, 4'd0, 1'b1, 1'b0);
        clear_counts();
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        check("entry_value", 32'(bcd_value), 32'h1234);
        check("entry_count", 32'(digit_count), 32'd4);
        press(4'd5);
        check("ovf_pulses", 32'(ov_seen), 32'd1);
        check("ovf_value", 32'(bcd_value), 32'h1234);

        // Invalid code
        clear_counts();
        press(4'hC);
        check("err_pulses", 32'(err_seen), 32'd1);
        check("err_value", 32'(bcd_value), 32'h1234);
        check("err_count", 32'(digit_count), 32'd4);

        // Clear colliding with acceptance of 9 while two digits are stored
        step(1'b0, 4'd0, 1'b1, 1'b0);
        press(4'd1);
        press(4'd2);
        clear_counts();
        for (int i = 0; i < DC - 1; i++) step(1'b1, 4'd9, 1'b0, 1'b0);
        step(1'b1, 4'd9, 1'b1, 1'b0);
        for (int i = 0; i < DC + 1; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
        check("collide_pulses", 32'(acc_seen + err_seen + ov_seen), 32'd0);
        check("collide_value", 32'(bcd_value), 32'h0000);
        press(4'd9);
        check("after_collide_value", 32'(bcd_value), 32'h0009);

        // Display scan of 0042
        step(1'b0, 4'd0, 1'b1, 1'b0);
        press(4'd4);
        press(4'd2);
        check("scan_value", 32'(bcd_value), 32'h0042);
        for (int i = 0; i < 4 * SD * 2; i++) step(1'b0, 4'd0, 1'b0, 1'b0);

        // Reset in the middle of a hold
        clear_counts();
        step(1'b1, 4'd3, 1'b0, 1'b0);
        step(1'b1, 4'd3, 1'b0, 1'b0);
        step(1'b1, 4'd3, 1'b0, 1'b1);
        for (int i = 0; i < DC - 1; i++) step(1'b1, 4'd3, 1'b0, 1'b0);
        check("rst_hold_no_early", 32'(acc_seen), 32'd0);
        step(1'b1, 4'd3, 1'b0, 1'b0);
        check("rst_hold_accepts", 32'(acc_seen), 32'd1);
        check("rst_hold_value", 32'(bcd_value), 32'h0003);
        for (int i = 0; i < DC + 1; i++) step(1'b0, 4'd0, 1'b0, 1'b0);

        // Random traffic with sticky key levels
        k = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) k = ~k;
            step(k, 4'($urandom_range(0, 11)), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
